// File: rtl/ita_regfile_port_ctrl_if.sv
// ita_regfile_port_ctrl_if
//   Bundles every non-clock/reset signal of the ITA register file port
//   controller: the write requester handshake, the read requester handshake
//   and response, the register file read/write port controls and init_done.
//   slave  : seen by the controller (ita_regfile_port_ctrl)
//   master : seen by the clients and the register file instance
interface ita_regfile_port_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_EN       = 4,
  parameter int N_READ     = 2,
  parameter int N_WREQ     = 3
);
  logic [N_WREQ-1:0]                 wreq_valid_i;
  logic [N_WREQ-1:0]                 wreq_ready_o;
  logic [N_WREQ-1:0][ADDR_WIDTH-1:0] wreq_addr_i;
  logic [N_WREQ-1:0][DATA_WIDTH-1:0] wreq_data_i;
  logic [N_WREQ-1:0][N_EN-1:0]       wreq_strb_i;

  logic [N_READ-1:0]                 rreq_valid_i;
  logic [N_READ-1:0]                 rreq_ready_o;
  logic [N_READ-1:0][ADDR_WIDTH-1:0] rreq_addr_i;
  logic [N_READ-1:0]                 rrsp_valid_o;
  logic [N_READ-1:0][DATA_WIDTH-1:0] rrsp_data_o;

  logic [N_READ-1:0]                 rf_read_enable_o;
  logic [N_READ-1:0][ADDR_WIDTH-1:0] rf_read_addr_o;
  logic [N_READ-1:0][DATA_WIDTH-1:0] rf_read_data_i;
  logic                              rf_write_enable_o;
  logic [ADDR_WIDTH-1:0]             rf_write_addr_o;
  logic [DATA_WIDTH-1:0]             rf_write_data_o;
  logic [N_EN-1:0]                   rf_write_select_o;

  logic                              init_done_o;

  modport slave (
    input  wreq_valid_i, wreq_addr_i, wreq_data_i, wreq_strb_i,
    output wreq_ready_o,
    input  rreq_valid_i, rreq_addr_i,
    output rreq_ready_o, rrsp_valid_o, rrsp_data_o,
    output rf_read_enable_o, rf_read_addr_o,
    input  rf_read_data_i,
    output rf_write_enable_o, rf_write_addr_o, rf_write_data_o, rf_write_select_o,
    output init_done_o
  );

  modport master (
    output wreq_valid_i, wreq_addr_i, wreq_data_i, wreq_strb_i,
    input  wreq_ready_o,
    output rreq_valid_i, rreq_addr_i,
    input  rreq_ready_o, rrsp_valid_o, rrsp_data_o,
    input  rf_read_enable_o, rf_read_addr_o,
    output rf_read_data_i,
    input  rf_write_enable_o, rf_write_addr_o, rf_write_data_o, rf_write_select_o,
    input  init_done_o
  );
endinterface

// File: rtl/ita_regfile_port_ctrl.sv
// ita_regfile_port_ctrl
//   Drives the single write port and N_READ read ports of the ITA latch-based
//   register file. Round-robin arbitrates N_WREQ write requesters onto the
//   write port, holds off reads that would observe a write still committing,
//   and (optionally) zero-fills the latch array after reset.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset
//     bus  - ita_regfile_port_ctrl_if.slave: write requests, read requests and
//            responses, register file control/data, init_done_o
//
//   Build option:
//     ITA_RF_INIT_ZERO_EN defined   -> INIT sweep writes 0 to every word after
//                                      reset, init_done_o rises afterwards.
//     ITA_RF_INIT_ZERO_EN undefined -> RUN straight out of reset,
//                                      init_done_o tied high.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   INIT  | zero sweep, one word per cycle, all requesters held off
//   RUN   | write arbitration and hazard-gated reads
module ita_regfile_port_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_EN       = 4,
  parameter int N_READ     = 2,
  parameter int N_WREQ     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  ita_regfile_port_ctrl_if.slave bus
);

  localparam int WIDX_W = (N_WREQ > 1) ? $clog2(N_WREQ) : 1;

  logic                  run_active;
  logic                  init_active;
  logic [ADDR_WIDTH-1:0] init_addr;

  logic [WIDX_W-1:0]     rr_q, rr_d;
  logic                  grant_vld;
  logic [WIDX_W-1:0]     grant_idx;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [N_EN-1:0]       wr_sel;
  logic [N_WREQ-1:0]     wr_ready;
  logic                  wr_hot;

  logic [ADDR_WIDTH-1:0] wprev_addr_q, wprev_addr_d;
  logic                  wprev_vld_q, wprev_vld_d;

  logic [N_READ-1:0]     rd_ready;
  logic [N_READ-1:0]     rd_en;
  logic [N_READ-1:0]     rrsp_vld_q, rrsp_vld_d;

  function automatic logic [WIDX_W-1:0] wrap_add(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N_WREQ) s = s - N_WREQ;
    return WIDX_W'(s);
  endfunction

`ifdef ITA_RF_INIT_ZERO_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (&init_cnt_q) state_d = ST_RUN;
    end
  end

  // The reset cycle itself is treated as neither INIT nor RUN so every
  // output is quiet while rst is high.
  always_comb begin
    init_active     = !rst && (state_q == ST_INIT);
    run_active      = !rst && (state_q == ST_RUN);
    init_addr       = init_cnt_q;
    bus.init_done_o = run_active;
  end
`else
  always_comb begin
    init_active     = 1'b0;
    run_active      = !rst;
    init_addr       = '0;
    bus.init_done_o = 1'b1;
  end
`endif

  // Scanning from the farthest offset down leaves the nearest valid
  // requester at or after rr_q as the final winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = N_WREQ - 1; k >= 0; k--) begin
      if (bus.wreq_valid_i[wrap_add(int'(rr_q), k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_add(int'(rr_q), k);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (run_active && grant_vld) rr_d = wrap_add(int'(grant_idx), 1);
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_sel   = '0;
    wr_ready = '0;
    if (init_active) begin
      wr_en   = 1'b1;
      wr_addr = init_addr;
      wr_sel  = '1;
    end else if (run_active && grant_vld) begin
      wr_en               = 1'b1;
      wr_addr             = bus.wreq_addr_i[grant_idx];
      wr_data             = bus.wreq_data_i[grant_idx];
      wr_sel              = bus.wreq_strb_i[grant_idx];
      wr_ready[grant_idx] = 1'b1;
    end
  end

  // Only writes that actually change a lane can make a read see stale data.
  assign wr_hot = wr_en && (wr_sel != '0);

  // A word written in cycle t is still committing in t+1, so a read of that
  // address is held off in both cycles.
  always_comb begin
    rd_ready = '0;
    rd_en    = '0;
    for (int z = 0; z < N_READ; z++) begin
      rd_ready[z] = run_active
                    && !(wr_hot && (bus.rreq_addr_i[z] == wr_addr))
                    && !(wprev_vld_q && (bus.rreq_addr_i[z] == wprev_addr_q));
      rd_en[z]    = bus.rreq_valid_i[z] && rd_ready[z];
    end
  end

  always_comb begin
    wprev_addr_d = wr_addr;
    wprev_vld_d  = wr_hot;
    rrsp_vld_d   = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= '0;
      wprev_addr_q <= '0;
      wprev_vld_q  <= 1'b0;
      rrsp_vld_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      wprev_addr_q <= wprev_addr_d;
      wprev_vld_q  <= wprev_vld_d;
      rrsp_vld_q   <= rrsp_vld_d;
    end
  end

  assign bus.wreq_ready_o      = wr_ready;
  assign bus.rf_write_enable_o = wr_en;
  assign bus.rf_write_addr_o   = wr_addr;
  assign bus.rf_write_data_o   = wr_data;
  assign bus.rf_write_select_o = wr_sel;

  assign bus.rreq_ready_o      = rd_ready;
  assign bus.rf_read_enable_o  = rd_en;
  assign bus.rf_read_addr_o    = bus.rreq_addr_i;
  assign bus.rrsp_valid_o      = rrsp_vld_q;
  assign bus.rrsp_data_o       = bus.rf_read_data_i;

endmodule

// File: tb/tb_ita_regfile_port_ctrl.sv
module tb_ita_regfile_port_ctrl;
  localparam int AW        = 5;
  localparam int DW        = 32;
  localparam int NE        = 4;
  localparam int NR        = 2;
  localparam int NW        = 3;
  localparam int NUM_WORDS = 1 << AW;
  localparam int LW        = DW / NE;
`ifdef ITA_RF_INIT_ZERO_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic fill;
  always #5 clk = ~clk;

  ita_regfile_port_ctrl_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_EN(NE), .N_READ(NR), .N_WREQ(NW)
  ) bus ();

  ita_regfile_port_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_EN(NE), .N_READ(NR), .N_WREQ(NW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Register file model: a write granted in t is captured at the end of t and
  // only lands in the array at the end of t+1; reads sample at the end of the
  // accept cycle, so reading too early returns stale contents.
  logic [DW-1:0]         mem [NUM_WORDS];
  logic [NR-1:0][DW-1:0] rd_q;
  logic                  pw_en;
  logic [AW-1:0]         pw_addr;
  logic [DW-1:0]         pw_data;
  logic [NE-1:0]         pw_sel;

  assign bus.rf_read_data_i = rd_q;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= $urandom;
      pw_en <= 1'b0;
    end else begin
      if (pw_en)
        for (int l = 0; l < NE; l++)
          if (pw_sel[l]) mem[pw_addr][l*LW +: LW] <= pw_data[l*LW +: LW];
      pw_en   <= bus.rf_write_enable_o;
      pw_addr <= bus.rf_write_addr_o;
      pw_data <= bus.rf_write_data_o;
      pw_sel  <= bus.rf_write_select_o;
    end
    for (int z = 0; z < NR; z++)
      if (bus.rf_read_enable_o[z]) rd_q[z] <= mem[bus.rf_read_addr_o[z]];
  end

  // Reference model state
  int unsigned   n_vec;
  int unsigned   n_err;
  int            m_rr;
  bit            m_in_init;
  int            m_cnt;
  bit            m_last_hot;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_mem   [NUM_WORDS];
  bit            m_known [NUM_WORDS];
  bit            m_pend       [NR];
  logic [DW-1:0] m_pend_data  [NR];
  bit            m_pend_known [NR];

  logic [NR-1:0]         obs_rready;
  logic [NR-1:0]         obs_acc;
  logic [NR-1:0]         obs_rsp;
  logic [NR-1:0][DW-1:0] obs_rsp_data;
  logic [NW-1:0]         obs_wready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic eval_cycle();
    int            g;
    bit            hot;
    bit            blocked;
    logic [AW-1:0] ga;
    logic [AW-1:0] ra;
    obs_rready   = bus.rreq_ready_o;
    obs_acc      = bus.rf_read_enable_o;
    obs_rsp      = bus.rrsp_valid_o;
    obs_rsp_data = bus.rrsp_data_o;
    obs_wready   = bus.wreq_ready_o;

    if (rst) begin
      chk("rst_wready", 64'(bus.wreq_ready_o), 64'(0));
      chk("rst_rready", 64'(bus.rreq_ready_o), 64'(0));
      chk("rst_wen", 64'(bus.rf_write_enable_o), 64'(0));
      chk("rst_ren", 64'(bus.rf_read_enable_o), 64'(0));
      chk("rst_init_done", 64'(bus.init_done_o), 64'(!INIT_EN));
      m_rr       = 0;
      m_in_init  = INIT_EN;
      m_cnt      = 0;
      m_last_hot = 1'b0;
      for (int z = 0; z < NR; z++) m_pend[z] = 1'b0;
      return;
    end

    for (int z = 0; z < NR; z++) begin
      chk($sformatf("rrsp_valid%0d", z), 64'(bus.rrsp_valid_o[z]), 64'(m_pend[z]));
      if (m_pend[z] && m_pend_known[z])
        chk($sformatf("rrsp_data%0d", z), 64'(bus.rrsp_data_o[z]), 64'(m_pend_data[z]));
    end

    if (m_in_init) begin
      chk("init_wen", 64'(bus.rf_write_enable_o), 64'(1));
      chk("init_waddr", 64'(bus.rf_write_addr_o), 64'(m_cnt));
      chk("init_wdata", 64'(bus.rf_write_data_o), 64'(0));
      chk("init_wsel", 64'(bus.rf_write_select_o), 64'((1 << NE) - 1));
      chk("init_wready", 64'(bus.wreq_ready_o), 64'(0));
      chk("init_rready", 64'(bus.rreq_ready_o), 64'(0));
      chk("init_done_lo", 64'(bus.init_done_o), 64'(0));
      m_mem[m_cnt]   = '0;
      m_known[m_cnt] = 1'b1;
      m_last_hot     = 1'b1;
      m_last_addr    = AW'(m_cnt);
      m_cnt++;
      if (m_cnt == NUM_WORDS) m_in_init = 1'b0;
      for (int z = 0; z < NR; z++) m_pend[z] = 1'b0;
      return;
    end

    g = -1;
    for (int k = 0; k < NW; k++)
      if (g < 0 && bus.wreq_valid_i[(m_rr + k) % NW]) g = (m_rr + k) % NW;
    chk("wready", 64'(bus.wreq_ready_o), (g >= 0) ? (64'(1) << g) : 64'(0));
    chk("wen", 64'(bus.rf_write_enable_o), 64'(g >= 0));
    chk("init_done_hi", 64'(bus.init_done_o), 64'(1));
    hot = 1'b0;
    ga  = '0;
    if (g >= 0) begin
      ga  = bus.wreq_addr_i[g];
      hot = (bus.wreq_strb_i[g] != '0);
      chk("waddr", 64'(bus.rf_write_addr_o), 64'(ga));
      chk("wdata", 64'(bus.rf_write_data_o), 64'(bus.wreq_data_i[g]));
      chk("wsel", 64'(bus.rf_write_select_o), 64'(bus.wreq_strb_i[g]));
    end

    for (int z = 0; z < NR; z++) begin
      ra      = bus.rreq_addr_i[z];
      blocked = (hot && ra == ga) || (m_last_hot && ra == m_last_addr);
      chk($sformatf("rready%0d", z), 64'(bus.rreq_ready_o[z]), 64'(!blocked));
      chk($sformatf("ren%0d", z), 64'(bus.rf_read_enable_o[z]),
          64'(bus.rreq_valid_i[z] && !blocked));
      if (bus.rreq_valid_i[z] && !blocked)
        chk($sformatf("raddr%0d", z), 64'(bus.rf_read_addr_o[z]), 64'(ra));
      m_pend[z]       = bus.rreq_valid_i[z] && !blocked;
      m_pend_data[z]  = m_mem[ra];
      m_pend_known[z] = m_known[ra];
    end

    if (g >= 0) begin
      for (int l = 0; l < NE; l++)
        if (bus.wreq_strb_i[g][l]) m_mem[ga][l*LW +: LW] = bus.wreq_data_i[g][l*LW +: LW];
      if (&bus.wreq_strb_i[g]) m_known[ga] = 1'b1;
      m_rr = (g + 1) % NW;
    end
    m_last_hot  = hot;
    m_last_addr = ga;
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wreq_valid_i = '0;
    bus.rreq_valid_i = '0;
  endtask

  task automatic set_wreq(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NE-1:0] s);
    bus.wreq_valid_i[w] = 1'b1;
    bus.wreq_addr_i[w]  = a;
    bus.wreq_data_i[w]  = d;
    bus.wreq_strb_i[w]  = s;
  endtask

  task automatic rand_inputs(input int addr_max);
    for (int w = 0; w < NW; w++) begin
      bus.wreq_valid_i[w] = 1'($urandom_range(0, 1));
      bus.wreq_addr_i[w]  = AW'($urandom_range(0, addr_max));
      bus.wreq_data_i[w]  = $urandom;
      bus.wreq_strb_i[w]  = ($urandom_range(0, 5) == 0) ? '0 : NE'($urandom_range(1, 15));
    end
    for (int z = 0; z < NR; z++) begin
      bus.rreq_valid_i[z] = 1'($urandom_range(0, 1));
      bus.rreq_addr_i[z]  = AW'($urandom_range(0, addr_max));
    end
  endtask

  task automatic rd_port0(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    bus.rreq_valid_i[0] = 1'b1;
    bus.rreq_addr_i[0]  = a;
    for (int i = 0; i < 8 && !ok; i++) begin
      step();
      if (obs_rsp[0]) begin
        ok = 1'b1;
        d  = obs_rsp_data[0];
      end
      if (obs_acc[0]) bus.rreq_valid_i[0] = 1'b0;
    end
    bus.rreq_valid_i[0] = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    bit            ok;
    logic [NR-1:0] rr_hist [4];
    n_vec = 0;
    n_err = 0;
    m_rr = 0; m_in_init = INIT_EN; m_cnt = 0; m_last_hot = 1'b0; m_last_addr = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    for (int z = 0; z < NR; z++) m_pend[z] = 1'b0;
    bus.wreq_addr_i = '0; bus.wreq_data_i = '0; bus.wreq_strb_i = '0;
    bus.rreq_addr_i = '0;
    idle();
    rst  = 1'b1;
    fill = 1'b1;
    step();
    fill = 1'b0;
    step();
    rst = 1'b0;

    // Bring-up (INIT sweep when enabled), then read back a swept word.
    repeat (NUM_WORDS + 2) step();
    rd_port0(AW'(7), d, ok);
    chk("rd7_timeout", 64'(ok), 64'(1));
`ifdef ITA_RF_INIT_ZERO_EN
    chk("rd7_zero", 64'(d), 64'(0));
`endif

    // Reset during the sweep restarts it.
    rst = 1'b1; step(); rst = 1'b0;
    repeat (10) step();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (NUM_WORDS + 1) step();

    // Preload every word through requester 2 so rr ends at 0.
    for (int a = 0; a < NUM_WORDS; a++) begin
      idle();
      set_wreq(2, AW'(a), $urandom, '1);
      step();
    end
    idle();
    step();

    // Round robin with everyone requesting.
    for (int w = 0; w < NW; w++) set_wreq(w, AW'(20 + w), $urandom, '1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq", 64'(obs_wready), 64'(1) << (i % NW));
    end
    idle();
    set_wreq(2, AW'(22), $urandom, '1);
    step();
    chk("rr_only2", 64'(obs_wready), 64'(4));
    idle();
    set_wreq(0, AW'(20), $urandom, '1);
    set_wreq(2, AW'(22), $urandom, '1);
    step();
    chk("rr_0and2", 64'(obs_wready), 64'(1));
    idle();
    step();

    // Read-after-write stall on address 5.
    set_wreq(0, AW'(5), 32'hDEADBEEF, '1);
    bus.rreq_valid_i[0] = 1'b1;
    bus.rreq_addr_i[0]  = AW'(5);
    step(); rr_hist[0] = obs_rready;
    bus.wreq_valid_i = '0;
    step(); rr_hist[1] = obs_rready;
    step(); rr_hist[2] = obs_rready;
    bus.rreq_valid_i[0] = 1'b0;
    step();
    chk("raw_t", 64'(rr_hist[0][0]), 64'(0));
    chk("raw_t1", 64'(rr_hist[1][0]), 64'(0));
    chk("raw_t2", 64'(rr_hist[2][0]), 64'(1));
    chk("raw_rsp_valid", 64'(obs_rsp[0]), 64'(1));
    chk("raw_rsp_data", 64'(obs_rsp_data[0]), 64'(32'hDEADBEEF));

    // Byte-lane merge.
    set_wreq(0, AW'(5), 32'h11223344, '1);
    step();
    idle();
    step(); step();
    set_wreq(0, AW'(5), 32'h0000AB00, 4'b0010);
    step();
    idle();
    step();
    rd_port0(AW'(5), d, ok);
    chk("rmw_timeout", 64'(ok), 64'(1));
    chk("rmw_data", 64'(d), 64'(32'h1122AB44));

    // A zero-strobe write does not stall a read of the same address.
    set_wreq(1, AW'(9), $urandom, '0);
    bus.rreq_valid_i[1] = 1'b1;
    bus.rreq_addr_i[1]  = AW'(9);
    step();
    chk("strb0_ready_t", 64'(obs_rready[1]), 64'(1));
    bus.wreq_valid_i = '0;
    step();
    chk("strb0_ready_t1", 64'(obs_rready[1]), 64'(1));
    idle();
    step();

    // Both read ports streaming on disjoint addresses.
    for (int i = 0; i < 8; i++) begin
      bus.rreq_valid_i   = '1;
      bus.rreq_addr_i[0] = AW'(i);
      bus.rreq_addr_i[1] = AW'(i + 8);
      step();
      chk("dual_ready", 64'(obs_rready), 64'(3));
    end
    idle();
    step();

    // Randomised traffic on a narrow address range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      rand_inputs(7);
      step();
    end
    idle();
    step();
    step();

    // Reset with a read response outstanding.
    bus.rreq_valid_i[0] = 1'b1;
    bus.rreq_addr_i[0]  = AW'(3);
    step();
    chk("pre_rst_acc", 64'(obs_acc[0]), 64'(1));
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rsp_dropped", 64'(obs_rsp[0]), 64'(0));
    repeat (INIT_EN ? NUM_WORDS - 1 : 0) step();
    for (int w = 0; w < NW; w++) set_wreq(w, AW'(24 + w), $urandom, '1);
    step();
    chk("rr_after_rst", 64'(obs_wready), 64'(1));
    idle();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ita_regfile_port_ctrl.md
# ita_regfile_port_ctrl

Controller for the ITA latch-based register file with a single write port and N_READ read ports. It round-robin arbitrates N_WREQ write requesters onto the single write port. It gates each read port against read-after-write hazards created by the file's one-cycle write-commit latency, and optionally zero-initialises the non-resettable latch array after reset. It sits between the ITA engine's buffer clients and the register file instance and drives all of the file's control inputs.

## Interface
- ADDR_WIDTH, 5, register file address width; NUM_WORDS = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width
- N_EN, 4, write-select lanes; DATA_WIDTH divisible by N_EN
- N_READ, 2, read ports / read requesters (1:1)
- N_WREQ, 3, write requesters, ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high (already decided)
- wreq_valid_i  in  [N_WREQ]  write request valid
- wreq_ready_o  out  [N_WREQ]  write grant; transfer when valid&ready
- wreq_addr_i  in  [N_WREQ][ADDR_WIDTH]  write address
- wreq_data_i  in  [N_WREQ][DATA_WIDTH]  write data
- wreq_strb_i  in  [N_WREQ][N_EN]  lane select
- rreq_valid_i  in  [N_READ]  read request valid
- rreq_ready_o  out  [N_READ]  read accept
- rreq_addr_i  in  [N_READ][ADDR_WIDTH]  read address
- rrsp_valid_o  out  [N_READ]  read data valid, one-cycle pulse, no backpressure
- rrsp_data_o  out  [N_READ][DATA_WIDTH]  read data
- rf_read_enable_o / rf_read_addr_o / rf_read_data_i  out/out/in  per-port  to file read ports
- rf_write_enable_o / rf_write_addr_o / rf_write_data_o / rf_write_select_o  out  1/ADDR_WIDTH/DATA_WIDTH/N_EN  to file write port
- init_done_o  out  1  high once the file is usable

## Operation
- States: INIT (sweep), RUN. Reset enters INIT if the macro is defined, else RUN.
- INIT: counter 0..NUM_WORDS-1. Each cycle: rf_write_enable_o=1, addr=counter, data=0, select=all ones. Counter at NUM_WORDS-1 → RUN next cycle. All ready outputs are 0 in INIT.
- RUN write arbitration: round-robin pointer rr_q, reset 0. Grant the first valid requester at or after rr_q, wrapping.
  - Grant is combinational: rf_write_* = granted requester's addr/data/strb, rf_write_enable_o=1, wreq_ready_o one-hot.
  - After a grant to index g, rr_q ← (g+1) mod N_WREQ. With no request, rr_q holds and rf_write_enable_o=0.
  - An all-zero strb grant is legal: enable=1, select=0, memory unchanged, not counted as a hazard write.
- Hazard tracking: register wprev_q (addr, valid) = the write issued last cycle, with valid only if strb≠0.
- RUN read gating, per port z: rreq_ready_o[z]=1 unless rreq_addr_i[z] equals a current-cycle write address (enable & strb≠0) or wprev_q.addr while wprev_q is valid. Stalls last at most 2 cycles per conflicting write.
- rf_read_enable_o[z] = rreq_valid_i[z] & rreq_ready_o[z]. rf_read_addr_o[z] = rreq_addr_i[z].
- rrsp_valid_o[z] ← accepted last cycle. rrsp_data_o[z] = rf_read_data_i[z], passed through. Data is meaningful only while rrsp_valid_o is high.
- Reads never stall writes; writes always take priority.
- Reset values: every ready 0 in the reset cycle; rrsp_valid_o=0; rf_write_enable_o=0; rf_read_enable_o=0; init_done_o=0 if the macro is defined, else 1; rr_q=0; wprev_q.valid=0.
- Reset mid-INIT or mid-RUN restarts at the reset state. An outstanding rrsp is dropped.

## Timing
- Write: granted in cycle t; the file samples data at the end of t and commits during t+1.
- Read: accepted in cycle t; rrsp_valid_o and data in t+1. Throughput is 1/cycle/port.
- Read-after-write to the same address: the earliest accept is t+2 after a write grant in t, so the response is in t+3.
- INIT takes NUM_WORDS cycles. init_done_o rises in the first RUN cycle.
- Combinational paths: wreq_valid_i → wreq_ready_o, rf_write_*, rreq_ready_o. No combinational path exists from rf_read_data_i to any control output.

## Configuration
- ITA_RF_INIT_ZERO_EN defined: INIT sweep present. Outputs are held off for NUM_WORDS cycles after reset. All words read 0 before their first write.
- Undefined: no INIT state or counter; RUN immediately after reset; init_done_o tied 1. Memory contents are undefined until written.

## Test plan
- Macro on, reset release → 32 cycles of zero writes to addr 0..31, select=4'hF; init_done_o=1 at cycle 32; a read of addr 7 returns 0.
- All 3 write requesters valid continuously → grants 0,1,2,0,1,2. With only requester 2 valid, then 0 and 2 valid → grant 2, then 0.
- Write addr 5 = 0xDEADBEEF in cycle t, read port 0 addr 5 valid from t → ready low in t and t+1, accepted t+2, rrsp in t+3 = 0xDEADBEEF.
- Write addr 5 with strb=4'b0010, data 0x0000AB00, over an old 0x11223344 → read returns 0x1122AB44. Strb=0 write → no read stall.
- Both read ports on different addresses with no conflict → ready=1 every cycle, rrsp_valid each next cycle, correct data.
- Assert rst in INIT cycle 10 and in RUN with a read outstanding → INIT restarts at addr 0, rrsp_valid_o=0 the cycle after, rr_q=0.
